// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI write-frame deserialiser and configuration register bank
// Frames are validated on ncs rise and committed one cycle later.
module spi_reg_ctrl #(
   parameter int SYNC_STAGES = 2,
   parameter int MAX_ADDR    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       copi,
   input  logic       ncs,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle,
   output logic       wr_strobe,
   output logic       frame_err
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_copi_sync;
   logic [SYNC_STAGES-1:0] r_ncs_sync;
   logic                   r_sclk_prev;
   logic                   r_ncs_prev;
   logic [SYNC_STAGES:0]   r_vld;
   logic [15:0]            r_shift;
   logic [4:0]             r_cnt;
   logic [7:0]             r_reg0, r_reg1, r_reg2, r_reg3, r_reg4;
   logic                   r_wr_strobe;
   logic                   r_frame_err;

   logic       w_sclk_s;
   logic       w_copi_s;
   logic       w_ncs_s;
   logic       w_sclk_rise;
   logic       w_ncs_rise;
   logic       w_ncs_fall;
   logic [6:0] w_addr;
   logic       w_addr_ok;

   assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
   assign w_copi_s    = r_copi_sync[SYNC_STAGES-1];
   assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
   assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
   assign w_ncs_rise  = w_ncs_s & ~r_ncs_prev;
   // The ncs reset value is not a real sample: a falling edge only counts once
   // the edge flop holds a value that came from the pin, so ncs held low
   // through reset never opens a frame.
   assign w_ncs_fall  = r_vld[SYNC_STAGES] & r_ncs_prev & ~w_ncs_s;
   assign w_addr      = r_shift[14:8];
   assign w_addr_ok   = (32'(w_addr) <= MAX_ADDR);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_ncs_fall) w_state_nxt = S_SHIFT;
         S_SHIFT:  if (w_ncs_rise) w_state_nxt = S_COMMIT;
         S_COMMIT: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sclk_sync <= '0;
         r_copi_sync <= '0;
         r_ncs_sync  <= '1;
         r_sclk_prev <= 1'b0;
         r_ncs_prev  <= 1'b1;
         r_vld       <= '0;
         r_shift     <= '0;
         r_cnt       <= '0;
         r_reg0      <= '0;
         r_reg1      <= '0;
         r_reg2      <= '0;
         r_reg3      <= '0;
         r_reg4      <= '0;
         r_wr_strobe <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
         r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
         r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
         r_sclk_prev <= w_sclk_s;
         r_ncs_prev  <= w_ncs_s;
         r_vld       <= {r_vld[SYNC_STAGES-1:0], 1'b1};
         r_wr_strobe <= 1'b0;
         r_frame_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_ncs_fall) begin
                  r_shift <= '0;
                  r_cnt   <= '0;
               end
            end
            S_SHIFT: begin
               // A coincident sclk edge is absorbed here before COMMIT evaluates.
               if (w_sclk_rise) begin
                  r_shift <= {r_shift[14:0], w_copi_s};
                  if (r_cnt != 5'd17) r_cnt <= r_cnt + 5'd1;
               end
            end
            S_COMMIT: begin
               if (r_cnt != 5'd16) begin
                  r_frame_err <= 1'b1;
               end else if (r_shift[15] && w_addr_ok) begin
                  r_wr_strobe <= 1'b1;
                  case (w_addr)
                     7'd0:    r_reg0 <= r_shift[7:0];
                     7'd1:    r_reg1 <= r_shift[7:0];
                     7'd2:    r_reg2 <= r_shift[7:0];
                     7'd3:    r_reg3 <= r_shift[7:0];
                     7'd4:    r_reg4 <= r_shift[7:0];
                     default: ;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

   assign en_reg_out_7_0  = r_reg0;
   assign en_reg_out_15_8 = r_reg1;
   assign en_reg_pwm_7_0  = r_reg2;
   assign en_reg_pwm_15_8 = r_reg3;
   assign pwm_duty_cycle  = r_reg4;
   assign wr_strobe       = r_wr_strobe;
   assign frame_err       = r_frame_err;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb/tb_spi_reg_ctrl.sv - scoreboard bench for spi_reg_ctrl
// Frames are modelled as whole words; expected commits are queued and popped by a monitor.
module tb_spi_reg_ctrl;

   localparam int SYNC_STAGES = 2;
   localparam int MAX_ADDR    = 4;
   localparam int HALF        = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sclk = 1'b0;
   logic       copi = 1'b0;
   logic       ncs = 1'b1;
   logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
   logic       wr_strobe, frame_err;

   spi_reg_ctrl #(.SYNC_STAGES(SYNC_STAGES), .MAX_ADDR(MAX_ADDR)) dut (
      .clk             (clk),
      .rst             (rst),
      .sclk            (sclk),
      .copi            (copi),
      .ncs             (ncs),
      .en_reg_out_7_0  (en_reg_out_7_0),
      .en_reg_out_15_8 (en_reg_out_15_8),
      .en_reg_pwm_7_0  (en_reg_pwm_7_0),
      .en_reg_pwm_15_8 (en_reg_pwm_15_8),
      .pwm_duty_cycle  (pwm_duty_cycle),
      .wr_strobe       (wr_strobe),
      .frame_err       (frame_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic        is_err;
      logic [31:0] cyc;
      logic [39:0] regs;
   } exp_t;

   exp_t        q[$];
   exp_t        mon_e;
   logic [7:0]  shadow[5];
   logic [39:0] cur_exp = '0;
   logic [39:0] outs;
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          in_rst = 1'b1;
   bit          chk_zero = 1'b0;
   bit          chk_end = 1'b0;

   assign outs = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};

   function automatic logic [39:0] snap();
      return {shadow[4], shadow[3], shadow[2], shadow[1], shadow[0]};
   endfunction

   always @(negedge clk) begin
      if (in_rst) begin
         cur_exp = '0;
      end else begin
         if (chk_zero) begin
            n_cmp++;
            if ({outs, wr_strobe, frame_err} !== 42'd0) begin
               n_bad++;
               $display("FAIL reset_state got=%h/%b/%b want=0/0/0", outs, wr_strobe, frame_err);
            end
         end
         if (chk_end) begin
            n_cmp++;
            if (q.size() != 0) begin
               n_bad++;
               $display("FAIL missing_commits got=%0d pending want=0", q.size());
            end
         end
         if (wr_strobe || frame_err) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_strobe cyc=%0d got wr=%b err=%b want none", cyc, wr_strobe, frame_err);
            end else begin
               mon_e = q.pop_front();
               n_cmp++;
               if ({wr_strobe, frame_err} !== (mon_e.is_err ? 2'b01 : 2'b10)) begin
                  n_bad++;
                  $display("FAIL strobe_kind got=%b%b want=%b", wr_strobe, frame_err,
                           (mon_e.is_err ? 2'b01 : 2'b10));
               end
               n_cmp++;
               if (cyc != int'(mon_e.cyc)) begin
                  n_bad++;
                  $display("FAIL commit_latency got cyc=%0d want cyc=%0d", cyc, mon_e.cyc);
               end
               n_cmp++;
               if (outs !== mon_e.regs) begin
                  n_bad++;
                  $display("FAIL commit_regs got=%h want=%h", outs, mon_e.regs);
               end
               cur_exp = mon_e.regs;
            end
         end else begin
            n_cmp++;
            if (outs !== cur_exp) begin
               n_bad++;
               $display("FAIL hold_regs cyc=%0d got=%h want=%h", cyc, outs, cur_exp);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      copi = b;
      tick(HALF);
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
   endtask

   task automatic begin_frame();
      ncs = 1'b0;
      tick(HALF);
   endtask

   // Closes the frame and records what the register bank must do with it.
   task automatic end_frame(input logic [31:0] word, input int nbits);
      exp_t e;
      tick(HALF);
      ncs = 1'b1;
      e.cyc = 32'(cyc + SYNC_STAGES + 2);
      if (nbits != 16) begin
         e.is_err = 1'b1;
         e.regs   = snap();
         q.push_back(e);
      end else if (word[15] && int'(word[14:8]) <= MAX_ADDR) begin
         shadow[int'(word[14:8])] = word[7:0];
         e.is_err = 1'b0;
         e.regs   = snap();
         q.push_back(e);
      end
      tick(SYNC_STAGES + 4);
   endtask

   task automatic send_frame(input logic [31:0] word, input int nbits);
      begin_frame();
      for (int i = nbits - 1; i >= 0; i--) send_bit(word[i]);
      end_frame(word, nbits);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_rst = 1'b1;
      q.delete();
      for (int i = 0; i < 5; i++) shadow[i] = 8'h00;
      tick(2);
      rst = 1'b0;
      in_rst = 1'b0;
      chk_zero = 1'b1;
      tick(1);
      chk_zero = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin
      int nb;
      logic [31:0] w;
      for (int i = 0; i < 5; i++) shadow[i] = 8'h00;
      tick(1);
      do_reset();

      for (int i = 0; i < 5; i++) begin
         sclk = 1'b1;
         tick(HALF);
         sclk = 1'b0;
         tick(HALF);
      end

      send_frame(32'h8455, 16);
      send_frame(32'h80F0, 16);
      send_frame(32'h810F, 16);
      send_frame(32'h82AA, 16);
      send_frame(32'h83FF, 16);
      send_frame(32'h0433, 16);
      send_frame(32'h8533, 16);
      send_frame(32'h4009, 15);
      send_frame(32'h10025, 17);
      send_frame(32'h8001, 16);

      begin_frame();
      for (int i = 15; i >= 8; i--) send_bit(w_bit(32'h8477, i));
      do_reset();
      tick(10);
      ncs = 1'b1;
      tick(20);

      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 5))
            0:       nb = 15;
            1:       nb = 17;
            default: nb = 16;
         endcase
         w = $urandom;
         w[14:8] = 7'($urandom_range(0, 6));
         send_frame(w, nb);
      end

      for (int i = 0; i < 100 && q.size() != 0; i++) tick(1);
      chk_end = 1'b1;
      tick(1);
      chk_end = 1'b0;
      tick(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   function automatic logic w_bit(input logic [31:0] word, input int idx);
      return word[idx];
   endfunction

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

SPI-peripheral configuration controller for the onboarding user project. It deserialises host SPI write frames arriving on the dedicated inputs and commits them into a small register bank. The bank drives the output-enable and PWM-enable masks and the PWM duty cycle consumed by the PWM datapath. It is the only writer of those registers, and it commits a frame only after that frame has been fully validated.

## Interface
Parameters:
- SYNC_STAGES, 2: flip-flops in each input synchroniser (sclk, copi, ncs); legal values are 2 or 3.
- MAX_ADDR, 4: highest valid register address; higher addresses are ignored.

Ports:
- clk  input  1  system clock; all logic runs on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- sclk  input  1  SPI serial clock, asynchronous to clk. Mode 0: data is sampled on the sclk rising edge.
- copi  input  1  SPI data, host to device, MSB first.
- ncs  input  1  SPI chip select, active-low.
- en_reg_out_7_0  output  8  register 0x00.
- en_reg_out_15_8  output  8  register 0x01.
- en_reg_pwm_7_0  output  8  register 0x02.
- en_reg_pwm_15_8  output  8  register 0x03.
- pwm_duty_cycle  output  8  register 0x04.
- wr_strobe  output  1  one-cycle pulse on every committed register write.
- frame_err  output  1  one-cycle pulse when a frame is discarded for a bad bit count.

## Operation
- **Synchronisers.** sclk, copi and ncs each pass through a SYNC_STAGES flop chain. One further flop per line holds the previous synchronised value for edge detection. Only synchronised values are used anywhere else in the block.
- **Frame format.** 16 bits, MSB first. Bit15 is R/W (1 = write). Bits 14:8 are the 7-bit address. Bits 7:0 are the data.
- **State machine.**
  - IDLE: waiting. A synchronised ncs falling edge moves to SHIFT, clears the shift register and clears the 5-bit bit counter.
  - SHIFT: each synchronised sclk rising edge shifts the synchronised copi into bit 0 and increments the counter. The counter saturates at 17.
  - SHIFT -> COMMIT on a synchronised ncs rising edge.
  - COMMIT: lasts exactly one cycle, then returns to IDLE.
- **Commit rules.**
  - Count == 16, bit15 = 1 and address <= MAX_ADDR: write the data to the addressed register and pulse wr_strobe.
  - Count == 16 with bit15 = 0 (read): ignored silently; no strobe, no error.
  - Count == 16 with address > MAX_ADDR: ignored silently.
  - Count != 16 (short or long frame): no write, frame_err pulses.
- **Ignored events.** sclk edges while ncs is high (IDLE) are ignored. An ncs falling edge while in SHIFT cannot occur, because ncs must rise first.
- **Simultaneous edges.** If sclk rises in the same cycle that ncs rises, that sclk edge is counted before the commit evaluation.
- **Reset.** rst overrides everything on the next clk edge:
  - all five registers go to 0x00;
  - wr_strobe and frame_err go to 0;
  - the FSM goes to IDLE, and the counter and shift register clear;
  - the synchroniser and edge flops reset to sclk = 0, copi = 0, ncs = 1.

  A frame in progress when rst is applied is lost. After rst deasserts, a frame is only recognised if ncs shows a fresh falling edge.

## Timing
- Every output is registered.
- Output values after reset: every register is 0x00, wr_strobe = 0, frame_err = 0.
- **Commit latency.** A change on the ncs pin that is stable before clk edge k is seen:
  - in the synchronised value after edge k+SYNC_STAGES-1;
  - as a detected edge during the following cycle;
  - with the register update and strobe visible after edge k+SYNC_STAGES+1.
- **Strobe timing.** wr_strobe or frame_err is high for exactly one clk cycle, coincident with the first cycle the new register value is visible.
- **Host constraints.**
  - The sclk high and low phases must each be at least SYNC_STAGES+1 clk periods; faster sclk is outside spec.
  - copi must be stable for that same window around each sclk rising edge.
  - ncs must stay high for at least SYNC_STAGES+2 clk periods between frames.
- **Back-to-back frames** that meet the ncs-high minimum each commit independently; no frame is dropped.

## Test plan
- Reset: hold rst for 2 cycles -> all registers are 0x00, wr_strobe = 0 and frame_err = 0. Then send sclk toggles with ncs high -> no change.
- Write frame 0x8455 (write, address 0x04, data 0x55) -> pwm_duty_cycle = 0x55 and a single-cycle wr_strobe. Check the latency matches SYNC_STAGES+2 edges from the ncs rise. All other registers stay 0x00.
- Back-to-back writes 0x80F0, 0x810F, 0x82AA, 0x83FF -> the registers read 0xF0, 0x0F, 0xAA, 0xFF; exactly four wr_strobe pulses; no frame_err.
- Read frame 0x0433 and write frame 0x8533 (address 5 > MAX_ADDR) -> no register change, no wr_strobe, no frame_err.
- Send a 15-bit frame, then a 17-bit frame, each with the write bit set and address 0x00 -> two frame_err pulses and en_reg_out_7_0 unchanged. A following valid frame 0x8001 -> en_reg_out_7_0 = 0x01.
- Assert rst after 8 bits of frame 0x8477 -> registers go to 0x00. ncs then rises with no new falling edge -> no write and no frame_err.
